// File: rtl/ppu_branch_pkg.sv
// Shared definitions for branch resolution: condition codes, flag bit positions, FSM states
// and the flag-condition evaluator used by the sequencer.
package ppu_branch_pkg;

    localparam logic [2:0] COND_NEVER = 3'b000;
    localparam logic [2:0] COND_Z     = 3'b001;
    localparam logic [2:0] COND_N     = 3'b010;
    localparam logic [2:0] COND_LE    = 3'b011;
    localparam logic [2:0] COND_C     = 3'b100;
    localparam logic [2:0] COND_CZ    = 3'b101;
    localparam logic [2:0] COND_V     = 3'b110;
    localparam logic [2:0] COND_NZ    = 3'b111;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;

    function automatic logic cond_eval(input logic [2:0] cond, input logic [3:0] flags);
        logic res;
        case (cond)
            COND_NEVER: res = 1'b0;
            COND_Z:     res = flags[FLAG_Z];
            COND_N:     res = flags[FLAG_N];
            COND_LE:    res = (flags[FLAG_N] ^ flags[FLAG_V]) | flags[FLAG_Z];
            COND_C:     res = flags[FLAG_C];
            COND_CZ:    res = flags[FLAG_C] | flags[FLAG_Z];
            COND_V:     res = flags[FLAG_V];
            default:    res = ~flags[FLAG_Z];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational jump decision: BL always jumps, COMB jumps on condition xor tf, otherwise falls through.
// Zero latency, no flow control.
module branch_cond_eval
    import ppu_branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       tf,
    input  logic       bl,
    input  logic       comb,
    input  logic [3:0] flags,
    output logic       jump
);

    always_comb begin
        jump = 1'b0;
        if (bl) begin
            jump = 1'b1;
        end else if (comb) begin
            jump = cond_eval(cond, flags) ^ tf;
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Branch resolution sequencer: owns {Z,N,C,V}, waits out flag hazards, pulses redirect/resolved one cycle
// after accept (or after flag_pending drops); br_ready only in IDLE, ID holds the branch otherwise.
module branch_sequencer
    import ppu_branch_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic              br_bl,
    input  logic              br_comb,
    input  logic              br_tf,
    input  logic [2:0]        br_cond,
    input  logic              br_nullify,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flag_we,
    input  logic [3:0]        flag_in,
    input  logic              flag_pending,
    input  logic              flush,
    output logic [3:0]        flags_q,
    output logic              stall,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              taken,
    output logic              resolved,
    output logic              nullify_ds,
    output logic              err_timeout
);

    localparam int               CNT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    logic [1:0]        state;
    logic              live;
    logic              bl_q;
    logic              comb_q;
    logic              tf_q;
    logic [2:0]        cond_q;
    logic              null_q;
    logic [ADDR_W-1:0] target_q;
    logic              jump_q;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              hazard;
    logic              in_idle;
    logic [3:0]        eval_flags;
    logic              jump;
    logic              out_pulse;

    assign in_idle    = (state == ST_IDLE);
    assign accept     = br_valid & br_ready;
    assign hazard     = br_comb & flag_pending & ~br_bl;
    assign eval_flags = flag_we ? flag_in : flags_q;

    // In IDLE the decision is made on the live ID fields, later on the latched copy.
    branch_cond_eval u_cond (
        .cond  (in_idle ? br_cond : cond_q),
        .tf    (in_idle ? br_tf   : tf_q),
        .bl    (in_idle ? br_bl   : bl_q),
        .comb  (in_idle ? br_comb : comb_q),
        .flags (eval_flags),
        .jump  (jump)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            live        <= 1'b0;
            flags_q     <= 4'b0000;
            bl_q        <= 1'b0;
            comb_q      <= 1'b0;
            tf_q        <= 1'b0;
            cond_q      <= 3'b000;
            null_q      <= 1'b0;
            target_q    <= '0;
            jump_q      <= 1'b0;
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flag_we) begin
                flags_q <= flag_in;
            end
            if (flush) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            bl_q     <= br_bl;
                            comb_q   <= br_comb;
                            tf_q     <= br_tf;
                            cond_q   <= br_cond;
                            null_q   <= br_nullify;
                            target_q <= br_target;
                            cnt      <= '0;
                            if (hazard) begin
                                state <= ST_WAIT;
                            end else begin
                                jump_q <= jump;
                                state  <= ST_RESOLVE;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (!flag_pending) begin
                            jump_q <= jump;
                            cnt    <= '0;
                            state  <= ST_RESOLVE;
                        end else if (cnt == CNT_MAX) begin
                            // Report only; the branch keeps waiting for its flags.
                            err_timeout <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RESOLVE: state <= ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_pulse   = (state == ST_RESOLVE) & ~flush;
    assign br_ready    = live & in_idle;
    assign stall       = (state == ST_WAIT);
    assign resolved    = out_pulse;
    assign taken       = out_pulse & jump_q;
    assign redirect    = out_pulse & jump_q;
    assign redirect_pc = target_q;
    assign nullify_ds  = out_pulse & null_q & (bl_q | ~jump_q);

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: vector table for single-branch resolution plus hazard/flush/timeout sequences.
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        br_valid, br_ready, br_bl, br_comb, br_tf, br_nullify;
    logic [2:0]  br_cond;
    logic [31:0] br_target;
    logic        flag_we, flag_pending, flush;
    logic [3:0]  flag_in, flags_q;
    logic        stall, redirect, taken, resolved, nullify_ds, err_timeout;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.ADDR_W(32), .WAIT_MAX(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .br_valid(br_valid), .br_ready(br_ready), .br_bl(br_bl), .br_comb(br_comb),
        .br_tf(br_tf), .br_cond(br_cond), .br_nullify(br_nullify), .br_target(br_target),
        .flag_we(flag_we), .flag_in(flag_in), .flag_pending(flag_pending), .flush(flush),
        .flags_q(flags_q), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .taken(taken), .resolved(resolved), .nullify_ds(nullify_ds), .err_timeout(err_timeout)
    );

    typedef struct {
        logic        bl, comb, tf;
        logic [2:0]  cond;
        logic        nul;
        logic [31:0] target;
        logic [3:0]  pre;
        logic        we;
        logic [3:0]  wf;
        logic        exp_taken, exp_null;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic bl, input logic comb, input logic tf, input logic [2:0] cond,
                                input logic nul, input logic [31:0] target, input logic [3:0] pre,
                                input logic we, input logic [3:0] wf, input logic et, input logic en);
        vec_t v;
        v.bl = bl; v.comb = comb; v.tf = tf; v.cond = cond; v.nul = nul; v.target = target;
        v.pre = pre; v.we = we; v.wf = wf; v.exp_taken = et; v.exp_null = en;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        br_valid = 1'b0; br_bl = 1'b0; br_comb = 1'b0; br_tf = 1'b0; br_cond = 3'b000;
        br_nullify = 1'b0; br_target = 32'h0; flag_we = 1'b0; flag_in = 4'b0000;
        flag_pending = 1'b0; flush = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_br_ready"}, br_ready, 1'b0);
        chk1({tag, "_stall"}, stall, 1'b0);
        chk1({tag, "_redirect"}, redirect, 1'b0);
        chk1({tag, "_resolved"}, resolved, 1'b0);
        chk1({tag, "_taken"}, taken, 1'b0);
        chk1({tag, "_nullify"}, nullify_ds, 1'b0);
        chk1({tag, "_err"}, err_timeout, 1'b0);
        chk4({tag, "_flags"}, flags_q, 4'b0000);
        chk32({tag, "_pc"}, redirect_pc, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        //            bl    comb  tf    cond    nul   target         pre      we    wf       taken null
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 32'h0000_0100, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 32'h0000_0110, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 32'h0000_0120, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 32'h0000_0130, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 3'b011, 1'b0, 32'h0000_0140, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 3'b011, 1'b1, 32'h0000_0150, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[6]  = mk(1'b0, 1'b1, 1'b0, 3'b100, 1'b0, 32'h0000_0160, 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 32'h0000_0170, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 32'h0000_0180, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 32'h0000_0190, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 32'h0000_01a0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0000_01b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0);

        #12;
        chk_all_zero("reset");
        cyc();
        reset_n = 1'b1;
        cyc();
        @(negedge clk);
        chk1("post_reset_ready", br_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            cyc();
            flag_we = 1'b1; flag_in = vecs[i].pre;
            cyc();
            flag_we = vecs[i].we; flag_in = vecs[i].wf;
            br_valid = 1'b1; br_bl = vecs[i].bl; br_comb = vecs[i].comb; br_tf = vecs[i].tf;
            br_cond = vecs[i].cond; br_nullify = vecs[i].nul; br_target = vecs[i].target;
            @(negedge clk);
            chk1($sformatf("v%0d_ready", i), br_ready, 1'b1);
            cyc();
            idle_inputs();
            @(negedge clk);
            chk1($sformatf("v%0d_resolved", i), resolved, 1'b1);
            chk1($sformatf("v%0d_taken", i), taken, vecs[i].exp_taken);
            chk1($sformatf("v%0d_redirect", i), redirect, vecs[i].exp_taken);
            if (vecs[i].exp_taken) chk32($sformatf("v%0d_pc", i), redirect_pc, vecs[i].target);
            chk1($sformatf("v%0d_nullify", i), nullify_ds, vecs[i].exp_null);
            chk1($sformatf("v%0d_busy", i), br_ready, 1'b0);
            chk4($sformatf("v%0d_flags", i), flags_q, vecs[i].we ? vecs[i].wf : vecs[i].pre);
            cyc();
            @(negedge clk);
            chk1($sformatf("v%0d_pulse_end", i), resolved, 1'b0);
            chk1($sformatf("v%0d_ready_again", i), br_ready, 1'b1);
        end

        // Flag hazard: pending for three cycles, flags arrive on the last one.
        cyc();
        flag_we = 1'b1; flag_in = 4'b0000;
        cyc();
        flag_we = 1'b0;
        br_valid = 1'b1; br_comb = 1'b1; br_cond = 3'b010; br_target = 32'h200; flag_pending = 1'b1;
        @(negedge clk); chk1("haz_accept", br_ready, 1'b1);
        cyc();
        br_valid = 1'b0;
        @(negedge clk); chk1("haz_stall1", stall, 1'b1); chk1("haz_nores1", resolved, 1'b0);
        cyc();
        flag_we = 1'b1; flag_in = 4'b0100;
        @(negedge clk); chk1("haz_stall2", stall, 1'b1);
        cyc();
        flag_we = 1'b0; flag_pending = 1'b0;
        @(negedge clk); chk1("haz_stall3", stall, 1'b1); chk4("haz_flags", flags_q, 4'b0100);
        cyc();
        @(negedge clk);
        chk1("haz_resolved", resolved, 1'b1); chk1("haz_taken", taken, 1'b1);
        chk32("haz_pc", redirect_pc, 32'h200); chk1("haz_stall_off", stall, 1'b0);
        cyc();
        idle_inputs();
        @(negedge clk); chk1("haz_ready", br_ready, 1'b1);

        // Flush while waiting: no pulse, back to IDLE, flag write still lands.
        br_valid = 1'b1; br_comb = 1'b1; br_cond = 3'b001; br_target = 32'h300; flag_pending = 1'b1;
        cyc();
        br_valid = 1'b0;
        @(negedge clk); chk1("fw_stall", stall, 1'b1);
        cyc();
        flush = 1'b1; flag_we = 1'b1; flag_in = 4'b1010;
        @(negedge clk); chk1("fw_nores", resolved, 1'b0); chk1("fw_noredir", redirect, 1'b0);
        cyc();
        idle_inputs();
        @(negedge clk);
        chk1("fw_ready", br_ready, 1'b1); chk1("fw_nostall", stall, 1'b0);
        chk4("fw_flags", flags_q, 4'b1010); chk1("fw_nores2", resolved, 1'b0);
        cyc();
        @(negedge clk); chk1("fw_nores3", resolved, 1'b0);

        // Flush in the resolve cycle suppresses all pulses.
        br_valid = 1'b1; br_bl = 1'b1; br_nullify = 1'b1; br_target = 32'h400;
        cyc();
        idle_inputs(); flush = 1'b1;
        @(negedge clk);
        chk1("fr_nores", resolved, 1'b0); chk1("fr_noredir", redirect, 1'b0); chk1("fr_nonull", nullify_ds, 1'b0);
        cyc();
        flush = 1'b0;
        @(negedge clk); chk1("fr_ready", br_ready, 1'b1); chk1("fr_nores2", resolved, 1'b0);

        // Flush coincident with accept drops the branch.
        br_valid = 1'b1; br_bl = 1'b1; br_target = 32'h440; flush = 1'b1;
        cyc();
        idle_inputs();
        @(negedge clk); chk1("fa_nores", resolved, 1'b0); chk1("fa_ready", br_ready, 1'b1);

        // Timeout: sixteen WAIT cycles before the sticky error appears.
        br_valid = 1'b1; br_comb = 1'b1; br_cond = 3'b001; br_target = 32'h500; flag_pending = 1'b1;
        cyc();
        br_valid = 1'b0;
        repeat (15) cyc();
        @(negedge clk); chk1("to_not_yet", err_timeout, 1'b0); chk1("to_stall", stall, 1'b1);
        cyc();
        @(negedge clk); chk1("to_raised", err_timeout, 1'b1);
        cyc();
        flag_pending = 1'b0;
        cyc();
        @(negedge clk);
        chk1("to_resolved", resolved, 1'b1); chk1("to_taken", taken, 1'b1);
        chk1("to_sticky", err_timeout, 1'b1);
        cyc();
        @(negedge clk); chk1("to_ready", br_ready, 1'b1);

        // Asynchronous reset in the middle of WAIT.
        cyc();
        br_valid = 1'b1; br_comb = 1'b1; br_cond = 3'b010; br_target = 32'h600; flag_pending = 1'b1;
        cyc();
        br_valid = 1'b0;
        @(negedge clk); chk1("rw_stall", stall, 1'b1);
        #1 reset_n = 1'b0;
        #1 chk_all_zero("rw");
        cyc();
        idle_inputs();
        reset_n = 1'b1;
        cyc();
        @(negedge clk);
        chk1("rw_ready", br_ready, 1'b1); chk1("rw_nores", resolved, 1'b0); chk1("rw_err", err_timeout, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
